id_ex_stage: RTL and testbench

//  ID/EX pipeline register feeding the ALU: captures the decoded instruction, resolves operand hazards and presents data1/data2/funct.
//  - Resolves RAW hazards by forwarding from EX (ALU result), EX/MEM and MEM/WB.
//  - Detects load-use hazards, inserts a bubble and stalls decode.
//  - Bubble/flush presents funct 4'b0000 (CERO), so the ALU drives 0.

---
 rtl/id_ex_stage_if.sv | 71 +++++++
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_if
// Purpose  : Bundle of decode-side, bypass-side and ALU-side signals of the
//            ID/EX pipeline register.
// Ports    : master - the surrounding pipeline (decode, EX/MEM, MEM/WB, ALU)
//            slave  - the id_ex_stage register itself
//            Decode : dec_valid, dec_rs1/2, dec_rs1/2_data, dec_imm,
//                     dec_use_imm, dec_funct, dec_rd, dec_reg_we, dec_mem_rd
//            Bypass : ex_result, mem_rd/we/data, wb_rd/we/data
//            Control: hold_in, flush -> stall_out
//            ALU    : alu_data1/2, alu_funct, ex_valid, ex_rd, ex_reg_we,
//                     ex_mem_rd, ex_store_data, bubble_cnt
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int FUNCT_W = 4,
  parameter int CNT_W   = 16
);
  logic               dec_valid;
  logic [REG_AW-1:0]  dec_rs1;
  logic [REG_AW-1:0]  dec_rs2;
  logic [DATA_W-1:0]  dec_rs1_data;
  logic [DATA_W-1:0]  dec_rs2_data;
  logic [DATA_W-1:0]  dec_imm;
  logic               dec_use_imm;
  logic [FUNCT_W-1:0] dec_funct;
  logic [REG_AW-1:0]  dec_rd;
  logic               dec_reg_we;
  logic               dec_mem_rd;
  logic [DATA_W-1:0]  ex_result;
  logic [REG_AW-1:0]  mem_rd;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_data;
  logic [REG_AW-1:0]  wb_rd;
  logic               wb_we;
  logic [DATA_W-1:0]  wb_data;
  logic               hold_in;
  logic               flush;
  logic               stall_out;
  logic [DATA_W-1:0]  alu_data1;
  logic [DATA_W-1:0]  alu_data2;
  logic [FUNCT_W-1:0] alu_funct;
  logic               ex_valid;
  logic [REG_AW-1:0]  ex_rd;
  logic               ex_reg_we;
  logic               ex_mem_rd;
  logic [DATA_W-1:0]  ex_store_data;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_data, dec_rs2_data, dec_imm,
           dec_use_imm, dec_funct, dec_rd, dec_reg_we, dec_mem_rd,
           ex_result, mem_rd, mem_we, mem_data, wb_rd, wb_we, wb_data,
           hold_in, flush,
    input  stall_out, alu_data1, alu_data2, alu_funct, ex_valid, ex_rd,
           ex_reg_we, ex_mem_rd, ex_store_data, bubble_cnt
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_data, dec_rs2_data, dec_imm,
           dec_use_imm, dec_funct, dec_rd, dec_reg_we, dec_mem_rd,
           ex_result, mem_rd, mem_we, mem_data, wb_rd, wb_we, wb_data,
           hold_in, flush,
    output stall_out, alu_data1, alu_data2, alu_funct, ex_valid, ex_rd,
           ex_reg_we, ex_mem_rd, ex_store_data, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register in front of the ALU. Resolves RAW
//            hazards by forwarding (EX > MEM > WB > register file), detects
//            load-use hazards and inserts a counted bubble while stalling
//            decode. Bubbles present funct 0 so the ALU drives zero.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - id_ex_if.slave (decode inputs, bypass inputs,
//                    hold/flush, ALU-side outputs, stall_out, bubble_cnt)
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int FUNCT_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  id_ex_if.slave bus
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // Pipeline registers
  logic [DATA_W-1:0]  alu_data1_q, alu_data1_d;
  logic [DATA_W-1:0]  alu_data2_q, alu_data2_d;
  logic [FUNCT_W-1:0] alu_funct_q, alu_funct_d;
  logic               ex_valid_q,  ex_valid_d;
  logic [REG_AW-1:0]  ex_rd_q,     ex_rd_d;
  logic               ex_reg_we_q, ex_reg_we_d;
  logic               ex_mem_rd_q, ex_mem_rd_d;
  logic [DATA_W-1:0]  store_q,     store_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

  logic               ex_fwd_en;
  logic               load_use;
  logic [DATA_W-1:0]  fwd1;
  logic [DATA_W-1:0]  fwd2;

  // Operand bypass select. A load in EX has no data yet, so it is excluded
  // here; that case is handled by the load-use bubble instead.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_en,
    input logic [REG_AW-1:0] ex_rd,
    input logic [DATA_W-1:0] ex_data,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_rd,
    input logic [DATA_W-1:0] mem_data,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] r;
    if (rs == '0)                      r = '0;
    else if (ex_en && ex_rd == rs)     r = ex_data;
    else if (mem_we && mem_rd == rs)   r = mem_data;
    else if (wb_we && wb_rd == rs)     r = wb_data;
    else                               r = rf_data;
    return r;
  endfunction

  assign ex_fwd_en = ex_valid_q & ex_reg_we_q & ~ex_mem_rd_q;

  assign fwd1 = fwd_sel(bus.dec_rs1, bus.dec_rs1_data, ex_fwd_en, ex_rd_q,
                        bus.ex_result, bus.mem_we, bus.mem_rd, bus.mem_data,
                        bus.wb_we, bus.wb_rd, bus.wb_data);
  assign fwd2 = fwd_sel(bus.dec_rs2, bus.dec_rs2_data, ex_fwd_en, ex_rd_q,
                        bus.ex_result, bus.mem_we, bus.mem_rd, bus.mem_data,
                        bus.wb_we, bus.wb_rd, bus.wb_data);

  // rs2 only counts as a dependency when data2 actually comes from it.
  assign load_use = bus.dec_valid & ex_valid_q & ex_mem_rd_q & (ex_rd_q != '0) &
                    ((ex_rd_q == bus.dec_rs1) |
                     (~bus.dec_use_imm & (ex_rd_q == bus.dec_rs2)));

  // Gated by rst_n so every output reads zero while reset is asserted.
  assign bus.stall_out = rst_n & (load_use | bus.hold_in);

  always_comb begin
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_funct_d  = alu_funct_q;
    ex_valid_d   = ex_valid_q;
    ex_rd_d      = ex_rd_q;
    ex_reg_we_d  = ex_reg_we_q;
    ex_mem_rd_d  = ex_mem_rd_q;
    store_d      = store_q;
    bubble_cnt_d = bubble_cnt_q;

    if (bus.flush || (!bus.hold_in && (load_use || !bus.dec_valid))) begin
      // Bubble: flush wins over hold; load-use and idle also land here.
      alu_data1_d = '0;
      alu_data2_d = '0;
      alu_funct_d = '0;
      ex_valid_d  = 1'b0;
      ex_rd_d     = '0;
      ex_reg_we_d = 1'b0;
      ex_mem_rd_d = 1'b0;
      store_d     = '0;
      // Only hazard bubbles are counted, never flushes or idle cycles.
      if (!bus.flush && load_use && bubble_cnt_q != C_CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else if (!bus.hold_in) begin
      alu_data1_d = fwd1;
      alu_data2_d = bus.dec_use_imm ? bus.dec_imm : fwd2;
      alu_funct_d = bus.dec_funct;
      ex_valid_d  = 1'b1;
      ex_rd_d     = bus.dec_rd;
      ex_reg_we_d = bus.dec_reg_we;
      ex_mem_rd_d = bus.dec_mem_rd;
      store_d     = fwd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      alu_funct_q  <= '0;
      ex_valid_q   <= 1'b0;
      ex_rd_q      <= '0;
      ex_reg_we_q  <= 1'b0;
      ex_mem_rd_q  <= 1'b0;
      store_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_funct_q  <= alu_funct_d;
      ex_valid_q   <= ex_valid_d;
      ex_rd_q      <= ex_rd_d;
      ex_reg_we_q  <= ex_reg_we_d;
      ex_mem_rd_q  <= ex_mem_rd_d;
      store_q      <= store_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.alu_data1     = alu_data1_q;
  assign bus.alu_data2     = alu_data2_q;
  assign bus.alu_funct     = alu_funct_q;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_reg_we     = ex_reg_we_q;
  assign bus.ex_mem_rd     = ex_mem_rd_q;
  assign bus.ex_store_data = store_q;
  assign bus.bubble_cnt    = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed self-checking bench for id_ex_stage. A second instance
//            with a 2-bit bubble counter shares the same stimulus so counter
//            saturation is reachable in a few cycles.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  id_ex_if #(.DATA_W(32), .REG_AW(5), .FUNCT_W(4), .CNT_W(16)) bus ();
  id_ex_if #(.DATA_W(32), .REG_AW(5), .FUNCT_W(4), .CNT_W(2))  bus_s ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .FUNCT_W(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .FUNCT_W(4), .CNT_W(2)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  assign bus_s.dec_valid    = bus.dec_valid;
  assign bus_s.dec_rs1      = bus.dec_rs1;
  assign bus_s.dec_rs2      = bus.dec_rs2;
  assign bus_s.dec_rs1_data = bus.dec_rs1_data;
  assign bus_s.dec_rs2_data = bus.dec_rs2_data;
  assign bus_s.dec_imm      = bus.dec_imm;
  assign bus_s.dec_use_imm  = bus.dec_use_imm;
  assign bus_s.dec_funct    = bus.dec_funct;
  assign bus_s.dec_rd       = bus.dec_rd;
  assign bus_s.dec_reg_we   = bus.dec_reg_we;
  assign bus_s.dec_mem_rd   = bus.dec_mem_rd;
  assign bus_s.ex_result    = bus.ex_result;
  assign bus_s.mem_rd       = bus.mem_rd;
  assign bus_s.mem_we       = bus.mem_we;
  assign bus_s.mem_data     = bus.mem_data;
  assign bus_s.wb_rd        = bus.wb_rd;
  assign bus_s.wb_we        = bus.wb_we;
  assign bus_s.wb_data      = bus.wb_data;
  assign bus_s.hold_in      = bus.hold_in;
  assign bus_s.flush        = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic use_imm,
                       input logic [3:0] fn, input logic [4:0] rd,
                       input logic we, input logic mrd);
    bus.dec_valid    = 1'b1;
    bus.dec_rs1      = rs1;
    bus.dec_rs2      = rs2;
    bus.dec_rs1_data = d1;
    bus.dec_rs2_data = d2;
    bus.dec_imm      = imm;
    bus.dec_use_imm  = use_imm;
    bus.dec_funct    = fn;
    bus.dec_rd       = rd;
    bus.dec_reg_we   = we;
    bus.dec_mem_rd   = mrd;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.dec_valid = 1'b0; bus.dec_rs1 = '0; bus.dec_rs2 = '0;
    bus.dec_rs1_data = '0; bus.dec_rs2_data = '0; bus.dec_imm = '0;
    bus.dec_use_imm = 1'b0; bus.dec_funct = '0; bus.dec_rd = '0;
    bus.dec_reg_we = 1'b0; bus.dec_mem_rd = 1'b0; bus.ex_result = '0;
    bus.mem_rd = '0; bus.mem_we = 1'b0; bus.mem_data = '0;
    bus.wb_rd = '0; bus.wb_we = 1'b0; bus.wb_data = '0;
    bus.hold_in = 1'b0; bus.flush = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_data1", bus.alu_data1, 0);
    check("rst_funct", bus.alu_funct, 0);
    check("rst_valid", bus.ex_valid, 0);
    check("rst_cnt",   bus.bubble_cnt, 0);
    check("rst_stall", bus.stall_out, 0);
    rst_n = 1'b1;

    // EX forward: ADD r3=r1+r2 (5+7), then SUB r4=r3-r1 with stale r3=0
    issue(5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 4'd1, 5'd3, 1'b1, 1'b0);
    tick();
    check("add_data1", bus.alu_data1, 5);
    check("add_data2", bus.alu_data2, 7);
    check("add_funct", bus.alu_funct, 1);
    check("add_valid", bus.ex_valid, 1);
    bus.ex_result = 32'd12;
    issue(5'd3, 5'd1, 32'd0, 32'd5, 32'd0, 1'b0, 4'd2, 5'd4, 1'b1, 1'b0);
    tick();
    check("exfwd_data1", bus.alu_data1, 12);
    check("exfwd_data2", bus.alu_data2, 5);

    // Priority: put an r3 writer in EX, then r3 also pending in MEM and WB
    issue(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd1, 5'd3, 1'b1, 1'b0);
    tick();
    bus.ex_result = 32'd12;
    bus.mem_we = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'd9;
    bus.wb_we  = 1'b1; bus.wb_rd  = 5'd3; bus.wb_data  = 32'd4;
    issue(5'd3, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd2, 5'd3, 1'b0, 1'b0);
    tick();
    check("prio_ex", bus.alu_data1, 12);
    tick(); // EX now holds rd=3 that does not write
    check("prio_mem", bus.alu_data1, 9);
    bus.mem_we = 1'b0;
    issue(5'd3, 5'd3, 32'd0, 32'd0, 32'd0, 1'b0, 4'd2, 5'd3, 1'b0, 1'b0);
    tick();
    check("prio_wb1", bus.alu_data1, 4);
    check("prio_wb2", bus.alu_data2, 4);
    // Immediate operand: data2 is imm, store data is forwarded rs2
    issue(5'd1, 5'd3, 32'd5, 32'h33, 32'hFFFF_FFF0, 1'b1, 4'd1, 5'd3, 1'b0, 1'b0);
    tick();
    check("imm_data1", bus.alu_data1, 5);
    check("imm_data2", bus.alu_data2, 32'hFFFF_FFF0);
    check("imm_store", bus.ex_store_data, 4);
    bus.wb_we = 1'b0;

    // Load-use: LOAD r5, then ADD r6=r5+r1
    issue(5'd1, 5'd0, 32'd5, 32'd0, 32'd8, 1'b1, 4'd1, 5'd5, 1'b1, 1'b1);
    tick();
    check("ld_memrd", bus.ex_mem_rd, 1);
    issue(5'd5, 5'd1, 32'd0, 32'd5, 32'd0, 1'b0, 4'd1, 5'd6, 1'b1, 1'b0);
    #1;
    check("lu_stall", bus.stall_out, 1);
    tick();
    check("lu_funct", bus.alu_funct, 0);
    check("lu_valid", bus.ex_valid, 0);
    check("lu_data1", bus.alu_data1, 0);
    check("lu_cnt",   bus.bubble_cnt, 1);
    bus.mem_we = 1'b1; bus.mem_rd = 5'd5; bus.mem_data = 32'h55;
    #1;
    check("lu_stall_clr", bus.stall_out, 0);
    tick();
    check("lu_issue_d1", bus.alu_data1, 32'h55);
    check("lu_issue_d2", bus.alu_data2, 5);
    check("lu_issue_fn", bus.alu_funct, 1);
    bus.mem_we = 1'b0;

    // Hold for 3 cycles with a different instruction waiting
    bus.hold_in = 1'b1;
    issue(5'd1, 5'd0, 32'h99, 32'd0, 32'd0, 1'b0, 4'd3, 5'd7, 1'b1, 1'b0);
    #1;
    check("hold_stall", bus.stall_out, 1);
    tick(); tick(); tick();
    check("hold_data1", bus.alu_data1, 32'h55);
    check("hold_funct", bus.alu_funct, 1);
    check("hold_rd",    bus.ex_rd, 6);
    bus.flush = 1'b1;
    tick();
    check("flush_valid", bus.ex_valid, 0);
    check("flush_funct", bus.alu_funct, 0);
    check("flush_data1", bus.alu_data1, 0);
    check("flush_cnt",   bus.bubble_cnt, 1);
    bus.hold_in = 1'b0; bus.flush = 1'b0;

    // rs1 = r0 must read zero even with a WB "write" to r0
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD;
    issue(5'd0, 5'd0, 32'h1234, 32'd0, 32'd0, 1'b0, 4'd1, 5'd9, 1'b1, 1'b0);
    tick();
    check("r0_data1", bus.alu_data1, 0);
    check("r0_valid", bus.ex_valid, 1);
    bus.wb_we = 1'b0;
    bus.dec_valid = 1'b0;
    tick();
    check("idle_valid", bus.ex_valid, 0);
    check("idle_cnt",   bus.bubble_cnt, 1);

    // Asynchronous reset mid-stream
    issue(5'd1, 5'd0, 32'h77, 32'd0, 32'd0, 1'b0, 4'd5, 5'd8, 1'b1, 1'b0);
    tick();
    check("pre_rst_d1", bus.alu_data1, 32'h77);
    bus.hold_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_data1", bus.alu_data1, 0);
    check("arst_funct", bus.alu_funct, 0);
    check("arst_valid", bus.ex_valid, 0);
    check("arst_cnt",   bus.bubble_cnt, 0);
    check("arst_cnt_s", bus_s.bubble_cnt, 0);
    check("arst_stall", bus.stall_out, 0);
    #1 rst_n = 1'b1;
    bus.hold_in = 1'b0;

    // Saturation: 16-bit counter keeps counting, 2-bit counter sticks at 3
    for (int k = 1; k <= 5; k++) begin
      issue(5'd1, 5'd0, 32'd5, 32'd0, 32'd8, 1'b1, 4'd1, 5'd5, 1'b1, 1'b1);
      tick();
      issue(5'd5, 5'd1, 32'd0, 32'd5, 32'd0, 1'b0, 4'd1, 5'd6, 1'b1, 1'b0);
      tick();
      tick();
      check($sformatf("sat_cnt_%0d", k),   bus.bubble_cnt, 64'(k));
      check($sformatf("sat_cnt_s_%0d", k), bus_s.bubble_cnt, (k < 3) ? 64'(k) : 64'd3);
    end
    bus.dec_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
